custom_counter_controller: RTL

Sequencer that drives the load/reset side of `custom_counter_unit` and consumes its `counter_expire`. It holds a programmable pattern of up to NUM_SLOTS interval configurations and steps through them. For each slot it issues `load` then `reset_counter`, waits for expiry, and counts expirations. It raises a sticky interrupt to the software-facing side on every expiry.

---
 rtl/custom_counter_controller.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/custom_counter_controller.sv
// Interval sequencer for custom_counter_unit: steps through a programmable
// slot pattern, pulsing load then reset_counter, and counts expiries.
module custom_counter_controller #(
    parameter int NUM_SLOTS   = 4,
    parameter int COUNT_WIDTH = 16,
    localparam int SW         = $clog2(NUM_SLOTS)
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   slot_we,
    input  logic [SW-1:0]          slot_addr,
    input  logic [1:0]             slot_data,
    input  logic [SW-1:0]          pattern_last,
    input  logic                   one_shot,
    input  logic                   counter_expire,
    output logic                   load,
    output logic [1:0]             load_config,
    output logic                   reset_counter,
    output logic                   irq,
    input  logic                   irq_ack,
    output logic [SW-1:0]          current_slot,
    output logic [COUNT_WIDTH-1:0] expire_count,
    output logic                   busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_WAIT
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [1:0]             r_slot [NUM_SLOTS];
    logic [SW-1:0]          r_cur;
    logic [SW-1:0]          r_last;
    logic                   r_one_shot;
    logic                   r_first;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_irq;
    logic                   r_load;
    logic [1:0]             r_cfg;
    logic                   r_rst;

    logic                   w_start_go;
    logic                   w_exp_ok;
    logic                   w_at_last;
    logic                   w_done;
    logic [SW-1:0]          w_cur_nxt;
    logic [1:0]             w_slot_rd;
    logic                   w_load_d;
    logic [1:0]             w_cfg_d;
    logic                   w_rst_d;

    assign w_start_go = (r_state == S_IDLE) && start && !stop;
    // The first WAIT cycle can still see the previous interval's expire.
    assign w_exp_ok   = (r_state == S_WAIT) && !r_first
                        && counter_expire && !stop;
    assign w_at_last  = (r_cur == r_last);
    assign w_done     = w_exp_ok && r_one_shot && w_at_last;

    always_comb begin
        w_cur_nxt = r_cur;
        if (w_start_go) begin
            w_cur_nxt = '0;
        end else if (w_exp_ok && !w_done) begin
            w_cur_nxt = w_at_last ? '0 : SW'(r_cur + 1'b1);
        end
    end

    // Bypass a slot write landing on the edge that enters LOAD.
    always_comb begin
        w_slot_rd = r_slot[w_cur_nxt];
        if (slot_we && (slot_addr == w_cur_nxt)) begin
            w_slot_rd = slot_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start_go) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_next = stop ? S_IDLE : S_ARM;
            end
            S_ARM: begin
                w_next = stop ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (stop || w_done) begin
                    w_next = S_IDLE;
                end else if (w_exp_ok) begin
                    w_next = S_LOAD;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_load_d = (w_next == S_LOAD);
        w_rst_d  = (w_next == S_ARM);
        w_cfg_d  = w_load_d ? w_slot_rd : 2'd0;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_load <= 1'b0;
            r_cfg  <= 2'd0;
            r_rst  <= 1'b0;
        end else begin
            r_load <= w_load_d;
            r_cfg  <= w_cfg_d;
            r_rst  <= w_rst_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_slot[i] <= 2'd1;
            end
        end else if (slot_we) begin
            r_slot[slot_addr] <= slot_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_cur      <= '0;
            r_last     <= '0;
            r_one_shot <= 1'b0;
            r_first    <= 1'b0;
            r_count    <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_cur   <= w_cur_nxt;
            r_first <= (r_state == S_ARM);
            if (w_start_go) begin
                r_last     <= pattern_last;
                r_one_shot <= one_shot;
            end
            if (w_start_go) begin
                r_count <= '0;
            end else if (w_exp_ok && (r_count != '1)) begin
                r_count <= COUNT_WIDTH'(r_count + 1'b1);
            end
            if (w_exp_ok) begin
                r_irq <= 1'b1;
            end else if (irq_ack) begin
                r_irq <= 1'b0;
            end
        end
    end

    assign load          = r_load;
    assign load_config   = r_cfg;
    assign reset_counter = r_rst;
    assign irq           = r_irq;
    assign current_slot  = r_cur;
    assign expire_count  = r_count;
    assign busy          = (r_state != S_IDLE);

endmodule
